// File: rtl/round_robin_stream_merge_2_if.sv
// rtl/round_robin_stream_merge_2_if.sv - handshake bundle for the two-input round-robin merger
//
// Purpose: groups both source streams and the merged output stream.
// Ports (signals):
//   in0_valid/in0_ready/in0_data/in0_last : source 0 stream
//   in1_valid/in1_ready/in1_data/in1_last : source 1 stream
//   out_valid/out_ready/out_data/out_last/out_src : merged output stream
// Modports: slave = merger side, master = producer/consumer side.
interface round_robin_stream_merge_2_if #(
  parameter int WIDTH = 8
);
  logic             in0_valid;
  logic             in0_ready;
  logic [WIDTH-1:0] in0_data;
  logic             in0_last;
  logic             in1_valid;
  logic             in1_ready;
  logic [WIDTH-1:0] in1_data;
  logic             in1_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_src;

  modport slave (
    input  in0_valid, in0_data, in0_last,
    input  in1_valid, in1_data, in1_last,
    input  out_ready,
    output in0_ready, in1_ready,
    output out_valid, out_data, out_last, out_src
  );

  modport master (
    output in0_valid, in0_data, in0_last,
    output in1_valid, in1_data, in1_last,
    output out_ready,
    input  in0_ready, in1_ready,
    input  out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/round_robin_stream_merge_2.sv
// rtl/round_robin_stream_merge_2.sv - two-input round-robin stream merger with input FIFOs
//
// Purpose: buffers each source in a FIFO_DEPTH-entry FIFO and forwards words onto one
// registered valid/ready output, choosing between sources round-robin.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : round_robin_stream_merge_2_if.slave (in0_*, in1_*, out_*)
// Optional feature: define RR_MERGE_PACKET_LOCK_EN to hold the grant on one source until
// it delivers a word with last = 1 (per-packet arbitration).
module round_robin_stream_merge_2 #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  round_robin_stream_merge_2_if.slave   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Stored word layout: {last, data}
  typedef logic [WIDTH:0] word_t;

  word_t            mem_q  [2][FIFO_DEPTH];
  logic [AW-1:0]    wptr_q [2];
  logic [AW-1:0]    wptr_d [2];
  logic [AW-1:0]    rptr_q [2];
  logic [AW-1:0]    rptr_d [2];
  logic [CW-1:0]    cnt_q  [2];
  logic [CW-1:0]    cnt_d  [2];
  word_t            in_word[2];
  word_t            head   [2];

  // run_q holds the readies low until the first edge after reset release
  logic             run_q, run_d;
  // prio_q is the source that wins a tie
  logic             prio_q, prio_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_src_q, out_src_d;
`ifdef RR_MERGE_PACKET_LOCK_EN
  logic             lock_q, lock_d;
`endif

  logic [1:0]       in_valid, in_ready, req, elig, push, pop;
  logic             load, gnt_valid, gnt_src;

  assign in_valid   = {bus.in1_valid, bus.in0_valid};
  assign in_word[0] = {bus.in0_last, bus.in0_data};
  assign in_word[1] = {bus.in1_last, bus.in1_data};

  assign bus.in0_ready = in_ready[0];
  assign bus.in1_ready = in_ready[1];
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      in_ready[k] = run_q && (cnt_q[k] != CW'(FIFO_DEPTH));
      req[k]      = (cnt_q[k] != '0);
      head[k]     = mem_q[k][rptr_q[k]];
    end
  end

  always_comb begin
    load = !out_valid_q || bus.out_ready;
    elig = req;
`ifdef RR_MERGE_PACKET_LOCK_EN
    // Mid-packet only the source that owns the packet may be granted; the locked
    // source is the one that supplied the word currently in the output register.
    if (lock_q) begin
      elig = req & (out_src_q ? 2'b10 : 2'b01);
    end
`endif
    gnt_valid = load && (elig != 2'b00);
    gnt_src   = (elig == 2'b11) ? prio_q : elig[1];

    run_d       = 1'b1;
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
`ifdef RR_MERGE_PACKET_LOCK_EN
    lock_d      = lock_q;
`endif
    if (load) begin
      out_valid_d = gnt_valid;
      if (gnt_valid) begin
        out_data_d = head[gnt_src][WIDTH-1:0];
        out_last_d = head[gnt_src][WIDTH];
        out_src_d  = gnt_src;
        prio_d     = !gnt_src;
`ifdef RR_MERGE_PACKET_LOCK_EN
        lock_d     = !head[gnt_src][WIDTH];
`endif
      end
    end

    for (int k = 0; k < 2; k++) begin
      push[k]   = in_valid[k] && in_ready[k];
      pop[k]    = gnt_valid && (gnt_src == 1'(k));
      wptr_d[k] = wptr_q[k] + AW'(push[k]);
      rptr_d[k] = rptr_q[k] + AW'(pop[k]);
      cnt_d[k]  = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q       <= 1'b0;
      prio_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
`ifdef RR_MERGE_PACKET_LOCK_EN
      lock_q      <= 1'b0;
`endif
      for (int k = 0; k < 2; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      run_q       <= run_d;
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
`ifdef RR_MERGE_PACKET_LOCK_EN
      lock_q      <= lock_d;
`endif
      for (int k = 0; k < 2; k++) begin
        wptr_q[k] <= wptr_d[k];
        rptr_q[k] <= rptr_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
    end
  end

  // Storage needs no reset: emptiness is tracked by the counters alone.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push[k]) begin
        mem_q[k][wptr_q[k]] <= in_word[k];
      end
    end
  end
endmodule

// File: tb/tb_round_robin_stream_merge_2.sv
// tb/tb_round_robin_stream_merge_2.sv - self-checking bench for round_robin_stream_merge_2
module tb_round_robin_stream_merge_2;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  round_robin_stream_merge_2_if #(.WIDTH(WIDTH)) bus ();

  round_robin_stream_merge_2 #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Words waiting at each producer: {last, data}
  logic [WIDTH:0]   src0_q[$];
  logic [WIDTH:0]   src1_q[$];
  // Output words accepted by the consumer: {src, last, data}
  logic [WIDTH+1:0] cap_q[$];
  logic [WIDTH+1:0] exp_q[$];

  // Reference model: FIFO contents as queues plus the output register.
  logic [WIDTH:0]   mq0[$];
  logic [WIDTH:0]   mq1[$];
  bit               m_run;
  bit               m_ov;
  logic [WIDTH-1:0] m_data;
  bit               m_last;
  bit               m_src;
  bit               m_winner;   // source that won the previous grant
  bit               m_lock;

  int  tick_no    = 0;
  int  sent_cnt   = 0;
  bit  saw_full   = 0;
  int  push1_tick = -1;
  int  out1_tick  = -1;

  task automatic model_clear();
    mq0.delete();
    mq1.delete();
    m_run    = 0;
    m_ov     = 0;
    m_data   = '0;
    m_last   = 0;
    m_src    = 0;
    m_winner = 1;    // so that the first tie goes to source 0
    m_lock   = 0;
  endtask

  task automatic tick(input bit rdy, input bit e0, input bit e1);
    logic [WIDTH:0] w0, w1, w;
    bit r0, r1, mp0, mp1, q0, q1, gs;
    w0 = (src0_q.size() > 0) ? src0_q[0] : '0;
    w1 = (src1_q.size() > 0) ? src1_q[0] : '0;
    bus.out_ready = rdy;
    bus.in0_valid = e0 && (src0_q.size() > 0);
    bus.in0_data  = w0[WIDTH-1:0];
    bus.in0_last  = w0[WIDTH];
    bus.in1_valid = e1 && (src1_q.size() > 0);
    bus.in1_data  = w1[WIDTH-1:0];
    bus.in1_last  = w1[WIDTH];
    #3;
    r0 = m_run && (mq0.size() < DEPTH);
    r1 = m_run && (mq1.size() < DEPTH);
    chk("in0_ready", 32'(bus.in0_ready), 32'(r0));
    chk("in1_ready", 32'(bus.in1_ready), 32'(r1));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("out_data",  32'(bus.out_data),  32'(m_data));
    chk("out_last",  32'(bus.out_last),  32'(m_last));
    chk("out_src",   32'(bus.out_src),   32'(m_src));
    if (m_run && (!bus.in0_ready || !bus.in1_ready)) saw_full = 1;
    if (bus.out_valid && rdy) cap_q.push_back({bus.out_src, bus.out_last, bus.out_data});
    if (bus.out_valid && bus.out_src && push1_tick >= 0 && out1_tick < 0) out1_tick = tick_no;
    // Producers advance on the handshake they actually see.
    if (bus.in0_valid && bus.in0_ready) begin void'(src0_q.pop_front()); sent_cnt++; end
    if (bus.in1_valid && bus.in1_ready) begin void'(src1_q.pop_front()); sent_cnt++; end
    mp0 = bus.in0_valid && r0;
    mp1 = bus.in1_valid && r1;
    if (mp1 && push1_tick < 0) push1_tick = tick_no;
    if (rst) begin
      q0 = mq0.size() > 0;
      q1 = mq1.size() > 0;
`ifdef RR_MERGE_PACKET_LOCK_EN
      if (m_lock) begin
        if (m_src) q0 = 0;
        else q1 = 0;
      end
`endif
      if (!m_ov || rdy) begin
        if (q0 || q1) begin
          gs = (q0 && q1) ? !m_winner : q1;
          w  = gs ? mq1.pop_front() : mq0.pop_front();
          m_ov     = 1;
          m_data   = w[WIDTH-1:0];
          m_last   = w[WIDTH];
          m_src    = gs;
          m_winner = gs;
`ifdef RR_MERGE_PACKET_LOCK_EN
          m_lock   = !w[WIDTH];
`endif
        end else begin
          m_ov = 0;
        end
      end
      if (mp0) mq0.push_back(w0);
      if (mp1) mq1.push_back(w1);
      m_run = 1;
    end
    tick_no++;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; reset is asserted between edges.
  task automatic do_reset(input int cycles);
    #2 rst = 1'b0;
    #1;
    chk("rst_in0_ready",  32'(bus.in0_ready), 32'd0);
    chk("rst_in1_ready",  32'(bus.in1_ready), 32'd0);
    chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_out_data",   32'(bus.out_data),  32'd0);
    chk("rst_out_last",   32'(bus.out_last),  32'd0);
    chk("rst_out_src",    32'(bus.out_src),   32'd0);
    model_clear();
    src0_q.delete();
    src1_q.delete();
    cap_q.delete();
    repeat (cycles) tick(1, 0, 0);
    #2 rst = 1'b1;
  endtask

  task automatic check_cap(input string tag);
    chk({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap_q.size()) chk(tag, 32'(cap_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.out_ready = 1'b0;
    bus.in0_valid = 1'b0;
    bus.in0_data  = '0;
    bus.in0_last  = 1'b0;
    bus.in1_valid = 1'b0;
    bus.in1_data  = '0;
    bus.in1_last  = 1'b0;
    model_clear();
    #1;

    // Reset and idle
    do_reset(3);
    repeat (3) tick(1, 0, 0);
    chk("idle_in0_ready", 32'(bus.in0_ready), 32'd1);
    chk("idle_in1_ready", 32'(bus.in1_ready), 32'd1);
    chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Tie-break from reset priority
    cap_q.delete();
    src0_q.push_back({1'b0, 8'hA0});
    src1_q.push_back({1'b0, 8'hB1});
    repeat (4) tick(1, 1, 1);
    exp_q.delete();
    exp_q.push_back({1'b0, 1'b0, 8'hA0});
    exp_q.push_back({1'b1, 1'b0, 8'hB1});
    check_cap("tie");

    // Alternation under backpressure
    cap_q.delete();
    saw_full = 0;
    src0_q.push_back({1'b0, 8'h01});
    src0_q.push_back({1'b0, 8'h02});
    src1_q.push_back({1'b0, 8'h11});
    src1_q.push_back({1'b0, 8'h12});
    repeat (3) tick(0, 1, 1);
    repeat (6) tick(1, 1, 1);
    exp_q.delete();
    exp_q.push_back({1'b0, 1'b0, 8'h01});
    exp_q.push_back({1'b1, 1'b0, 8'h11});
    exp_q.push_back({1'b0, 1'b0, 8'h02});
    exp_q.push_back({1'b1, 1'b0, 8'h12});
    check_cap("alt");
    chk("alt_fifo_full", 32'(saw_full), 32'd1);

    // No starvation: source 0 streams, source 1 injects one word
    for (int i = 0; i < 10; i++) src0_q.push_back({1'b1, 8'(8'h40 + i)});
    src1_q.push_back({1'b1, 8'h5A});
    push1_tick = -1;
    out1_tick  = -1;
    for (int i = 0; i < 16; i++) tick(1, 1, i >= 3);
    chk("starve_seen", 32'(out1_tick >= 0 && push1_tick >= 0), 32'd1);
    chk("starve_lat_le2", 32'((out1_tick - 1 - push1_tick) <= 2), 32'd1);

    // Reset mid-operation with buffered words
    for (int i = 0; i < 4; i++) begin
      src0_q.push_back({1'b0, 8'(8'h60 + i)});
      src1_q.push_back({1'b0, 8'(8'h70 + i)});
    end
    repeat (3) tick(0, 1, 1);
    do_reset(2);
    repeat (3) tick(1, 0, 0);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    // Packet lock scenario
    cap_q.delete();
    src0_q.push_back({1'b0, 8'h20});
    src0_q.push_back({1'b0, 8'h21});
    src0_q.push_back({1'b1, 8'h22});
    src1_q.push_back({1'b1, 8'h30});
    repeat (8) tick(1, 1, 1);
    exp_q.delete();
`ifdef RR_MERGE_PACKET_LOCK_EN
    exp_q.push_back({1'b0, 1'b0, 8'h20});
    exp_q.push_back({1'b0, 1'b0, 8'h21});
    exp_q.push_back({1'b0, 1'b1, 8'h22});
    exp_q.push_back({1'b1, 1'b1, 8'h30});
`else
    exp_q.push_back({1'b0, 1'b0, 8'h20});
    exp_q.push_back({1'b1, 1'b1, 8'h30});
    exp_q.push_back({1'b0, 1'b0, 8'h21});
    exp_q.push_back({1'b0, 1'b1, 8'h22});
`endif
    check_cap("pkt");

    // Randomized traffic against the model
    cap_q.delete();
    sent_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (src0_q.size() < 4 && $urandom_range(0, 99) < 50)
        src0_q.push_back({1'($urandom_range(0, 99) < 30), 8'($urandom)});
      if (src1_q.size() < 4 && $urandom_range(0, 99) < 50)
        src1_q.push_back({1'($urandom_range(0, 99) < 30), 8'($urandom)});
      tick($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70);
    end
    // Close any open packet so the drain can finish
    src0_q.push_back({1'b1, 8'hEE});
    src1_q.push_back({1'b1, 8'hEF});
    begin
      bit done;
      done = 0;
      for (int i = 0; i < 200 && !done; i++) begin
        tick(1, 1, 1);
        done = (src0_q.size() == 0) && (src1_q.size() == 0) &&
               (mq0.size() == 0) && (mq1.size() == 0) && !m_ov;
      end
      chk("drain_done", 32'(done), 32'd1);
    end
    chk("word_count", 32'(cap_q.size()), 32'(sent_cnt));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
